// File: rtl/radix2_div_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM states and the
// placement of quotient/remainder inside the packed result word.
package radix2_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int QUO_LSB = 0;

  // Remainder sits directly above the quotient in {remainder, quotient}.
  function automatic int rem_lsb(input int width);
    return width;
  endfunction

endpackage

// File: rtl/radix2_div_step.sv
// One restoring radix-2 step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference on no borrow, otherwise restore.
module radix2_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;

  // The partial remainder stays below the divisor, so the WIDTH+1-bit
  // difference always fits in its low WIDTH bits when there is no borrow.
  always_comb begin
    trial_s  = {rem, bit_in};
    borrow_s = (trial_s < {1'b0, divisor});
    diff_s   = trial_s[WIDTH-1:0] - divisor;
    if (borrow_s) begin
      rem_next = trial_s[WIDTH-1:0];
      q_bit    = 1'b0;
    end else begin
      rem_next = diff_s;
      q_bit    = 1'b1;
    end
  end

endmodule

// File: rtl/radix2_div_n.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready handshakes
// on both the request and the result side.
module radix2_div_n
  import radix2_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sign,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               opn_valid,
  output logic               opn_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW      = $clog2(WIDTH + 1);
  localparam int REM_LSB = rem_lsb(WIDTH);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             mode_r, dvd_neg_r, dvs_neg_r, zero_r, ovf_r;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;

  logic             dvd_neg_s, dvs_neg_s, zero_s, ovf_s, q_bit_s;
  logic [WIDTH-1:0] dvd_abs_s, dvs_abs_s, rem_next_s, quo_fix_s, rem_fix_s;

  radix2_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .bit_in   (quo_r[WIDTH-1]),
    .divisor  (dvs_r),
    .rem_next (rem_next_s),
    .q_bit    (q_bit_s)
  );

  // Operand conditioning at accept and sign correction of the final result.
  always_comb begin
    dvd_neg_s = sign & dividend[WIDTH-1];
    dvs_neg_s = sign & divisor[WIDTH-1];
    zero_s    = (divisor == {WIDTH{1'b0}});
    ovf_s     = sign && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     && (divisor == {WIDTH{1'b1}});
    if (dvd_neg_s) dvd_abs_s = -dividend;
    else           dvd_abs_s = dividend;
    if (dvs_neg_s) dvs_abs_s = -divisor;
    else           dvs_abs_s = divisor;
    if (mode_r && (dvd_neg_r ^ dvs_neg_r)) quo_fix_s = -quo_r;
    else                                   quo_fix_s = quo_r;
    if (mode_r && dvd_neg_r) rem_fix_s = -rem_r;
    else                     rem_fix_s = rem_r;
  end

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      mode_r      <= 1'b0;
      dvd_neg_r   <= 1'b0;
      dvs_neg_r   <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      opn_ready   <= 1'b1;
      res_valid   <= 1'b0;
      result      <= {(2*WIDTH){1'b0}};
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (opn_valid) begin
            mode_r    <= sign;
            dvd_neg_r <= dividend[WIDTH-1];
            dvs_neg_r <= divisor[WIDTH-1];
            zero_r    <= zero_s;
            ovf_r     <= ovf_s;
            dvs_r     <= dvs_abs_s;
            rem_r     <= {WIDTH{1'b0}};
            // A zero divisor skips CALC; the raw dividend rides in quo_r to FIX.
            quo_r     <= zero_s ? dividend : dvd_abs_s;
            cnt_r     <= {CW{1'b0}};
            opn_ready <= 1'b0;
            state_r   <= zero_s ? FIX : CALC;
          end else begin
            opn_ready <= 1'b1;
          end
        end
        CALC: begin
          {rem_r, quo_r} <= {rem_next_s, quo_r[WIDTH-2:0], q_bit_s};
          cnt_r          <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) state_r <= FIX;
          else                         state_r <= CALC;
        end
        FIX: begin
          if (zero_r) begin
            result[REM_LSB +: WIDTH] <= quo_r;
            result[QUO_LSB +: WIDTH] <= {WIDTH{1'b1}};
          end else begin
            result[REM_LSB +: WIDTH] <= rem_fix_s;
            result[QUO_LSB +: WIDTH] <= quo_fix_s;
          end
          div_by_zero <= zero_r;
          overflow    <= ovf_r & ~zero_r;
          res_valid   <= 1'b1;
          cnt_r       <= {CW{1'b0}};
          state_r     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            opn_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          opn_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
